// File: rtl/collenda_debug_scan_bridge.sv
// Debug scan bridge: a virtual-JTAG style instruction/data register pair.
// Captured readback shifts out on tdo, and full-length scans commit as a valid/ready action.
module collenda_debug_scan_bridge #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic                         vs_cdr,
  input  logic                         vs_sdr,
  input  logic                         vs_udr,
  input  logic                         tdi,
  output logic                         tdo,
  input  logic [(2**IR_W)*DATA_W-1:0]  cap_data,
  output logic [DATA_W-1:0]            jdo,
  output logic [IR_W-1:0]              act_ch,
  output logic                         act_valid,
  input  logic                         act_ready,
  output logic                         scan_err,
  input  logic                         err_clr
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SHIFT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IR_W-1:0]     r_ir;
  logic [DATA_W-1:0]   r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_jdo;
  logic [IR_W-1:0]     r_act_ch;
  logic                r_act_valid;
  logic                r_scan_err;

  logic                w_active;
  logic                w_do_cdr;
  logic                w_do_sdr;
  logic                w_do_udr;
  logic                w_commit;
  logic                w_set_err;
  logic [DATA_W-1:0]   w_cap_word;

  assign w_cap_word = cap_data[int'(r_ir)*DATA_W +: DATA_W];

  // Strobes are qualified by priority here so the datapath only sees one winner.
  always_comb begin
    w_active     = (r_state != ST_IDLE);
    w_do_cdr     = !vs_uir && vs_cdr;
    w_do_sdr     = !vs_uir && !vs_cdr && vs_sdr && w_active;
    w_do_udr     = !vs_uir && !vs_cdr && !vs_sdr && vs_udr && w_active;
    w_commit     = w_do_udr && (r_cnt == CNT_FULL) && (!r_act_valid || act_ready);
    w_set_err    = w_do_udr && !w_commit;
    w_state_next = r_state;
    if (vs_uir) begin
      w_state_next = ST_IDLE;
    end else if (w_do_cdr) begin
      w_state_next = ST_CAPT;
    end else if (w_do_sdr) begin
      w_state_next = ST_SHIFT;
    end else if (w_do_udr) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ir        <= '0;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_jdo       <= '0;
      r_act_ch    <= '0;
      r_act_valid <= 1'b0;
      r_scan_err  <= 1'b0;
    end else begin
      if (vs_uir) begin
        r_ir  <= ir_in;
        r_cnt <= '0;
      end else if (w_do_cdr) begin
        r_sr  <= w_cap_word;
        r_cnt <= '0;
      end else if (w_do_sdr) begin
        r_sr <= {tdi, r_sr[DATA_W-1:1]};
        // Saturating one past full length keeps over-length scans distinguishable.
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (w_commit) begin
        r_jdo       <= r_sr;
        r_act_ch    <= r_ir;
        r_act_valid <= 1'b1;
      end else if (r_act_valid && act_ready) begin
        r_act_valid <= 1'b0;
      end

      if (w_set_err) begin
        r_scan_err <= 1'b1;
      end else if (err_clr) begin
        r_scan_err <= 1'b0;
      end
    end
  end

  assign tdo       = r_sr[0];
  assign jdo       = r_jdo;
  assign act_ch    = r_act_ch;
  assign act_valid = r_act_valid;
  assign scan_err  = r_scan_err;

endmodule
